// File: rtl/debug_cmd_pkg.sv
// Shared types and sizing helpers for the debug-slave command decoder.
// Optional feature macro used by the decoder: DEBUG_CMD_PARITY_EN.
package debug_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StShift,
        StUpdate
    } cmd_state_e;

    localparam int unsigned NUM_CH_DEFAULT = 4;

    function automatic int unsigned calc_num_ch(input int unsigned ir_w);
        return 32'd1 << ir_w;
    endfunction

    // Counter must represent DR_W+1 so over-long scans stay distinguishable.
    function automatic int unsigned calc_cnt_w(input int unsigned dr_w);
        return $clog2(dr_w + 2);
    endfunction

endpackage

// File: rtl/debug_dr_shifter.sv
// DR shift register with per-channel capture mux and saturating bit counter.
module debug_dr_shifter
    import debug_cmd_pkg::*;
#(
    parameter int unsigned DR_W = 38,
    parameter int unsigned IR_W = 2,
    localparam int unsigned NUM_CH = calc_num_ch(IR_W),
    localparam int unsigned CNT_W = calc_cnt_w(DR_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     shift,
    input  logic                     tdi,
    input  logic [IR_W-1:0]          sel,
    input  logic [NUM_CH*DR_W-1:0]   cap_data,
    output logic [DR_W-1:0]          sr,
    output logic [CNT_W-1:0]         cnt
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DR_W + 1);

    logic [DR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = cap_data[DR_W*int'(sel) +: DR_W];
            cnt_d = '0;
        end else if (shift) begin
            sr_d = {tdi, sr_q[DR_W-1:1]};
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr  = sr_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/debug_slave_cmd_decoder.sv
// Debug-command front end: IR latch, DR scan FSM and per-channel action decode.
// Define DEBUG_CMD_PARITY_EN to require even parity (sr[0]) on every updated DR word.
module debug_slave_cmd_decoder
    import debug_cmd_pkg::*;
#(
    parameter int unsigned DR_W    = 38,
    parameter int unsigned IR_W    = 2,
    parameter int unsigned ACT_BIT = DR_W - 1,
    localparam int unsigned NUM_CH = calc_num_ch(IR_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IR_W-1:0]        ir_in,
    input  logic                   vs_uir,
    input  logic                   vs_cdr,
    input  logic                   vs_sdr,
    input  logic                   shift_en,
    input  logic                   vs_udr,
    input  logic                   tdi,
    input  logic [NUM_CH*DR_W-1:0] cap_data,
    output logic                   tdo,
    output logic [DR_W-1:0]        jdo,
    output logic [IR_W-1:0]        ir_q,
    output logic [NUM_CH-1:0]      take_action,
    output logic [NUM_CH-1:0]      take_no_action,
    output logic                   scan_err,
    output logic                   busy
);

    localparam int unsigned CNT_W = calc_cnt_w(DR_W);

    cmd_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_d;
    logic [DR_W-1:0]   jdo_q, jdo_d;
    logic [NUM_CH-1:0] act_q, act_d;
    logic [NUM_CH-1:0] noact_q, noact_d;
    logic              err_q, err_d;

    logic [DR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;
    logic              load;
    logic              shift;
    logic              update_go;
    logic              parity_ok;
    logic              good;

    // vs_uir overrides everything; vs_udr overrides a shift in the same cycle.
    assign load      = (state_q == StCapture) && !vs_uir;
    assign shift     = (state_q == StShift) && vs_sdr && shift_en && !vs_uir && !vs_udr;
    assign update_go = (state_q == StShift) && vs_udr && !vs_uir;

`ifdef DEBUG_CMD_PARITY_EN
    assign parity_ok = ~(^sr);
`else
    assign parity_ok = 1'b1;
`endif

    assign good = (cnt == CNT_W'(DR_W)) && parity_ok;

    debug_dr_shifter #(
        .DR_W (DR_W),
        .IR_W (IR_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .tdi      (tdi),
        .sel      (ir_q),
        .cap_data (cap_data),
        .sr       (sr),
        .cnt      (cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (vs_cdr) state_d = StCapture;
            StCapture: state_d = StShift;
            StShift: begin
                if (vs_udr) begin
                    state_d = StUpdate;
                end else if (vs_cdr) begin
                    state_d = StCapture;
                end
            end
            StUpdate:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (vs_uir) begin
            state_d = StIdle;
        end
    end

    // Decode is registered on the edge entering UPDATE so the pulse and jdo are
    // visible during the UPDATE cycle, one cycle after vs_udr.
    always_comb begin
        ir_d    = vs_uir ? ir_in : ir_q;
        jdo_d   = jdo_q;
        act_d   = '0;
        noact_d = '0;
        err_d   = err_q;
        if (load) begin
            err_d = 1'b0;
        end
        if (update_go) begin
            if (good) begin
                jdo_d = sr;
                if (sr[ACT_BIT]) begin
                    act_d[ir_q] = 1'b1;
                end else begin
                    noact_d[ir_q] = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ir_q    <= '0;
            jdo_q   <= '0;
            act_q   <= '0;
            noact_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            jdo_q   <= jdo_d;
            act_q   <= act_d;
            noact_q <= noact_d;
            err_q   <= err_d;
        end
    end

    assign tdo            = sr[0];
    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign scan_err       = err_q;
    assign busy           = (state_q == StCapture) || (state_q == StShift);

endmodule

// File: tb/tb_debug_slave_cmd_decoder.sv
// Randomized scoreboard bench for debug_slave_cmd_decoder (DR_W=38, IR_W=2).
// Models DEBUG_CMD_PARITY_EN when the macro is defined for the build.
module tb_debug_slave_cmd_decoder;

    localparam int DR_W    = 38;
    localparam int IR_W    = 2;
    localparam int NUM_CH  = 4;
    localparam int ACT_BIT = DR_W - 1;

    logic                   clk;
    logic                   reset;
    logic [IR_W-1:0]        ir_in;
    logic                   vs_uir, vs_cdr, vs_sdr, shift_en, vs_udr, tdi;
    logic [NUM_CH*DR_W-1:0] cap_data;
    logic                   tdo;
    logic [DR_W-1:0]        jdo;
    logic [IR_W-1:0]        ir_q;
    logic [NUM_CH-1:0]      take_action, take_no_action;
    logic                   scan_err, busy;

    debug_slave_cmd_decoder #(
        .DR_W    (DR_W),
        .IR_W    (IR_W),
        .ACT_BIT (ACT_BIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ir_in          (ir_in),
        .vs_uir         (vs_uir),
        .vs_cdr         (vs_cdr),
        .vs_sdr         (vs_sdr),
        .shift_en       (shift_en),
        .vs_udr         (vs_udr),
        .tdi            (tdi),
        .cap_data       (cap_data),
        .tdo            (tdo),
        .jdo            (jdo),
        .ir_q           (ir_q),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .scan_err       (scan_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              is_err;
        bit              act;
        int unsigned     ch;
        logic [DR_W-1:0] jdo;
    } exp_t;

    exp_t            sb[$];
    logic [DR_W-1:0] model_jdo;
    int              total = 0;
    int              bad = 0;
    logic            prev_err = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DR_W-1:0] fix_par(input logic [DR_W-1:0] w);
        logic [DR_W-1:0] r;
        r = w;
`ifdef DEBUG_CMD_PARITY_EN
        r[0] = ^w[DR_W-1:1];
`endif
        return r;
    endfunction

    function automatic logic [DR_W-1:0] rand_word();
        return DR_W'({$urandom, $urandom});
    endfunction

    // Monitor: every pulse or fresh error must match the oldest expectation.
    always @(negedge clk) begin
        exp_t            e;
        logic [NUM_CH-1:0] ev;
        if (!reset) begin
            if ((take_action != 0) || (take_no_action != 0)) begin
                check("sb_has_entry_pulse", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    ev = '0;
                    ev[e.ch] = 1'b1;
                    check("event_kind_pulse", e.is_err, 0);
                    check("take_action", take_action, e.act ? ev : '0);
                    check("take_no_action", take_no_action, e.act ? '0 : ev);
                    check("jdo_on_pulse", jdo, e.jdo);
                end
            end else if (scan_err && !prev_err) begin
                check("sb_has_entry_err", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("event_kind_err", e.is_err, 1);
                    check("jdo_held_on_err", jdo, e.jdo);
                end
            end
        end
        prev_err <= scan_err;
    end

    task automatic start_scan(input logic [IR_W-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick();
        vs_uir = 1'b0;
        check("ir_latched", ir_q, ir);
        vs_cdr = 1'b1;
        tick();
        vs_cdr = 1'b0;
        tick();
        check("capture_clears_err", scan_err, 0);
        check("busy_in_shift", busy, 1);
        check("tdo_capture", tdo, cap_data[DR_W*int'(ir)]);
    endtask

    task automatic shift_bits(input logic [DR_W-1:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                vs_sdr   = 1'($urandom_range(0, 1));
                shift_en = !vs_sdr;
                tdi      = 1'($urandom);
                tick();
            end
            vs_sdr   = 1'b1;
            shift_en = 1'b1;
            tdi      = (i < DR_W) ? word[i] : 1'($urandom);
            tick();
        end
        vs_sdr   = 1'b0;
        shift_en = 1'b0;
    endtask

    task automatic do_scan(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] word,
                           input int n, input bit with_cdr);
        exp_t e;
        bit   good;
        start_scan(ir);
        shift_bits(word, n);
        good = (n == DR_W);
`ifdef DEBUG_CMD_PARITY_EN
        good = good && ((^word) == 1'b0);
`endif
        if (good) model_jdo = word;
        e.is_err = !good;
        e.act    = word[ACT_BIT];
        e.ch     = int'(ir);
        e.jdo    = model_jdo;
        sb.push_back(e);
        vs_udr = 1'b1;
        vs_cdr = with_cdr;
        tick();
        vs_udr = 1'b0;
        vs_cdr = 1'b0;
        check("pulse_latency", (|take_action) | (|take_no_action), good);
        check("busy_in_update", busy, 0);
        tick();
        check("pulse_one_cycle", (|take_action) | (|take_no_action), 0);
        check("idle_after_update", busy, 0);
        check("scan_err_after", scan_err, !good);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DR_W-1:0] w;
        int              n;
        int              r;
        reset = 1'b1;
        {ir_in, vs_uir, vs_cdr, vs_sdr, shift_en, vs_udr, tdi} = '0;
        for (int c = 0; c < NUM_CH; c++) cap_data[c*DR_W +: DR_W] = rand_word();
        model_jdo = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_jdo", jdo, 0);
        check("rst_ir_q", ir_q, 0);
        check("rst_take_action", take_action, 0);
        check("rst_take_no_action", take_no_action, 0);
        check("rst_scan_err", scan_err, 0);
        check("rst_busy", busy, 0);
        check("rst_tdo", tdo, 0);

        // Action scan on channel 2, then no-action on channel 1.
        w = rand_word();
        w[ACT_BIT] = 1'b1;
        do_scan(2'd2, fix_par(w), DR_W, 1'b0);
        w = rand_word();
        w[ACT_BIT] = 1'b0;
        do_scan(2'd1, fix_par(w), DR_W, 1'b0);

        // Short scan flags an error; the next capture clears it inside start_scan.
        do_scan(2'd3, fix_par(rand_word()), DR_W - 1, 1'b0);
        do_scan(2'd0, fix_par(rand_word()), DR_W + 3, 1'b0);

        // Update beats a simultaneous capture.
        do_scan(2'd3, fix_par(rand_word()), DR_W, 1'b1);

`ifdef DEBUG_CMD_PARITY_EN
        w = fix_par(rand_word());
        w[0] = ~w[0];
        do_scan(2'd2, w, DR_W, 1'b0);
        do_scan(2'd2, fix_par(rand_word()), DR_W, 1'b0);
`endif

        // New IR mid-scan aborts without a pulse; stray vs_udr in IDLE is ignored.
        start_scan(2'd1);
        shift_bits(rand_word(), 10);
        ir_in  = 2'd3;
        vs_uir = 1'b1;
        tick();
        vs_uir = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ir_q", ir_q, 3);
        vs_udr = 1'b1;
        tick();
        vs_udr = 1'b0;
        check("idle_udr_no_pulse", (|take_action) | (|take_no_action), 0);
        check("idle_udr_jdo", jdo, model_jdo);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 7);
            if (r <= 3)      n = DR_W;
            else if (r == 4) n = DR_W - 1;
            else if (r == 5) n = DR_W + 1;
            else if (r == 6) n = DR_W + 3;
            else             n = $urandom_range(0, DR_W - 2);
            w = rand_word();
            if ($urandom_range(0, 3) != 0) w = fix_par(w);
            do_scan(2'($urandom), w, n, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a shift (17 bits in) drops everything.
        start_scan(2'd2);
        shift_bits(rand_word(), 17);
        reset = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_jdo", jdo, 0);
        check("midrst_ir_q", ir_q, 0);
        check("midrst_pulse", (|take_action) | (|take_no_action), 0);
        check("midrst_err", scan_err, 0);
        reset = 1'b0;
        model_jdo = '0;
        tick();
        do_scan(2'd1, fix_par(rand_word()), DR_W, 1'b0);

        for (int t = 0; t < 10 && sb.size() != 0; t++) tick();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
